// File: rtl/pipe_stall_ctrl.sv
// Stall controller for the 5-stage core: load-use hazard detection,
// multi-cycle EX sequencing and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
    parameter int CNT_W  = 6,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              id_reg1_read_i,
    input  logic [4:0]        id_reg1_addr_i,
    input  logic              id_reg2_read_i,
    input  logic [4:0]        id_reg2_addr_i,
    input  logic              ex_is_load_i,
    input  logic              ex_wreg_i,
    input  logic [4:0]        ex_wd_i,
    input  logic              ex_mc_req_i,
    input  logic [CNT_W-1:0]  ex_mc_len_i,
    output logic [5:0]        stall_o,
    output logic              ex_mc_done_o,
    output logic              busy_o,
    output logic [STAT_W-1:0] stall_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [5:0] STALL_EX = 6'b001111;
    localparam logic [5:0] STALL_LU = 6'b000111;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STAT_W-1:0]   stat_q, stat_d;
    logic                ld_haz;
    logic                rs1_hit;
    logic                rs2_hit;
    logic [5:0]          stall;
    logic                done;

    assign rs1_hit = id_reg1_read_i && (id_reg1_addr_i == ex_wd_i);
    assign rs2_hit = id_reg2_read_i && (id_reg2_addr_i == ex_wd_i);
    assign ld_haz  = ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0)
                     && (rs1_hit || rs2_hit);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 6'b0;
        done    = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ex_mc_req_i && (ex_mc_len_i != '0)) begin
                        stall   = STALL_EX;
                        cnt_d   = ex_mc_len_i - CNT_W'(1);
                        state_d = BUSY;
                    end else begin
                        done  = ex_mc_req_i;
                        stall = ld_haz ? STALL_LU : 6'b0;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        stall = STALL_EX;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        // request is still the finishing op; ignore it here
                        done    = 1'b1;
                        stall   = ld_haz ? STALL_LU : 6'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        stat_d = stat_q;
        if ((stall != 6'b0) && !(&stat_q)) begin
            stat_d = stat_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stat_q  <= stat_d;
        end
    end

    // outputs are forced quiet while reset is held
    assign stall_o      = rst ? stall : 6'b0;
    assign ex_mc_done_o = rst & done;
    assign busy_o       = rst & (state_q == BUSY);
    assign stall_cnt_o  = stat_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: reset, load-use, multi-cycle,
// edge lengths, back-to-back, flush and statistics saturation.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        id_reg1_read_i;
    logic [4:0]  id_reg1_addr_i;
    logic        id_reg2_read_i;
    logic [4:0]  id_reg2_addr_i;
    logic        ex_is_load_i;
    logic        ex_wreg_i;
    logic [4:0]  ex_wd_i;
    logic        ex_mc_req_i;
    logic [5:0]  ex_mc_len_i;
    logic [5:0]  stall_o;
    logic        ex_mc_done_o;
    logic        busy_o;
    logic [31:0] stall_cnt_o;
    logic [5:0]  s4_stall_o;
    logic        s4_done_o;
    logic        s4_busy_o;
    logic [3:0]  s4_cnt_o;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .id_reg1_read_i (id_reg1_read_i),
        .id_reg1_addr_i (id_reg1_addr_i),
        .id_reg2_read_i (id_reg2_read_i),
        .id_reg2_addr_i (id_reg2_addr_i),
        .ex_is_load_i   (ex_is_load_i),
        .ex_wreg_i      (ex_wreg_i),
        .ex_wd_i        (ex_wd_i),
        .ex_mc_req_i    (ex_mc_req_i),
        .ex_mc_len_i    (ex_mc_len_i),
        .stall_o        (stall_o),
        .ex_mc_done_o   (ex_mc_done_o),
        .busy_o         (busy_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    pipe_stall_ctrl #(.CNT_W(6), .STAT_W(4)) dut4 (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .id_reg1_read_i (id_reg1_read_i),
        .id_reg1_addr_i (id_reg1_addr_i),
        .id_reg2_read_i (id_reg2_read_i),
        .id_reg2_addr_i (id_reg2_addr_i),
        .ex_is_load_i   (ex_is_load_i),
        .ex_wreg_i      (ex_wreg_i),
        .ex_wd_i        (ex_wd_i),
        .ex_mc_req_i    (ex_mc_req_i),
        .ex_mc_len_i    (ex_mc_len_i),
        .stall_o        (s4_stall_o),
        .ex_mc_done_o   (s4_done_o),
        .busy_o         (s4_busy_o),
        .stall_cnt_o    (s4_cnt_o)
    );

    task automatic clear_inputs();
        flush_i        = 1'b0;
        id_reg1_read_i = 1'b0;
        id_reg1_addr_i = 5'd0;
        id_reg2_read_i = 1'b0;
        id_reg2_addr_i = 5'd0;
        ex_is_load_i   = 1'b0;
        ex_wreg_i      = 1'b0;
        ex_wd_i        = 5'd0;
        ex_mc_req_i    = 1'b0;
        ex_mc_len_i    = 6'd0;
    endtask

    task automatic set_ld_haz(input logic on);
        ex_is_load_i   = on;
        ex_wreg_i      = on;
        ex_wd_i        = on ? 5'd9 : 5'd0;
        id_reg1_read_i = on;
        id_reg1_addr_i = on ? 5'd9 : 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        ex_mc_req_i = 1'b1;
        ex_mc_len_i = 6'd3;
        set_ld_haz(1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vec++;
            if (stall_o !== 6'b0 || busy_o !== 1'b0 || ex_mc_done_o !== 1'b0) begin
                err++;
                $display("FAIL reset_outs c%0d: stall=%b busy=%b done=%b, want 0/0/0",
                         c, stall_o, busy_o, ex_mc_done_o);
            end
            vec++;
            if (stall_cnt_o !== 32'd0) begin
                err++;
                $display("FAIL reset_cnt c%0d: got %0d want 0", c, stall_cnt_o);
            end
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if (stall_o !== 6'b001111 || busy_o !== 1'b0) begin
            err++;
            $display("FAIL reset_resume: stall=%b busy=%b want 001111/0",
                     stall_o, busy_o);
        end
        next_cycle();
        @(negedge clk);
        vec++;
        if (busy_o !== 1'b1) begin
            err++;
            $display("FAIL reset_resume_busy: got %b want 1", busy_o);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        pulse_reset();
        ex_is_load_i   = 1'b1;
        ex_wreg_i      = 1'b1;
        ex_wd_i        = 5'd5;
        id_reg2_read_i = 1'b1;
        id_reg2_addr_i = 5'd5;
        @(negedge clk);
        vec++;
        if (stall_o !== 6'b000111) begin
            err++;
            $display("FAIL lu_rs2: got %b want 000111", stall_o);
        end
        next_cycle();
        ex_is_load_i = 1'b0;
        @(negedge clk);
        vec++;
        if (stall_o !== 6'b0 || stall_cnt_o !== 32'd1) begin
            err++;
            $display("FAIL lu_release: stall=%b cnt=%0d want 000000/1",
                     stall_o, stall_cnt_o);
        end
        next_cycle();
        ex_is_load_i   = 1'b1;
        ex_wd_i        = 5'd0;
        id_reg2_addr_i = 5'd0;
        @(negedge clk);
        vec++;
        if (stall_o !== 6'b0) begin
            err++;
            $display("FAIL lu_x0: got %b want 000000", stall_o);
        end
        next_cycle();
        ex_wd_i        = 5'd7;
        id_reg2_read_i = 1'b0;
        id_reg2_addr_i = 5'd7;
        @(negedge clk);
        vec++;
        if (stall_o !== 6'b0) begin
            err++;
            $display("FAIL lu_noread: got %b want 000000", stall_o);
        end
        next_cycle();
        id_reg1_read_i = 1'b1;
        id_reg1_addr_i = 5'd7;
        @(negedge clk);
        vec++;
        if (stall_o !== 6'b000111) begin
            err++;
            $display("FAIL lu_rs1: got %b want 000111", stall_o);
        end
        next_cycle();
        ex_wreg_i = 1'b0;
        @(negedge clk);
        vec++;
        if (stall_o !== 6'b0) begin
            err++;
            $display("FAIL lu_nowreg: got %b want 000000", stall_o);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_multicycle();
        logic [5:0] exp_stall;
        pulse_reset();
        ex_mc_req_i = 1'b1;
        ex_mc_len_i = 6'd3;
        set_ld_haz(1'b1);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) set_ld_haz(1'b0);
            exp_stall = (c < 3) ? 6'b001111 : 6'b0;
            @(negedge clk);
            vec++;
            if (stall_o !== exp_stall || ex_mc_done_o !== (c == 3)
                || busy_o !== (c >= 1)) begin
                err++;
                $display("FAIL mc3 c%0d: stall=%b done=%b busy=%b want %b/%b/%b",
                         c, stall_o, ex_mc_done_o, busy_o, exp_stall,
                         (c == 3), (c >= 1));
            end
            next_cycle();
        end
        ex_mc_req_i = 1'b0;
        @(negedge clk);
        vec++;
        if (stall_cnt_o !== 32'd3 || busy_o !== 1'b0 || ex_mc_done_o !== 1'b0) begin
            err++;
            $display("FAIL mc3_after: cnt=%0d busy=%b done=%b want 3/0/0",
                     stall_cnt_o, busy_o, ex_mc_done_o);
        end
        next_cycle();
    endtask

    task automatic test_edge_lengths();
        int stalls;
        int done_at;
        pulse_reset();
        ex_mc_req_i = 1'b1;
        ex_mc_len_i = 6'd0;
        @(negedge clk);
        vec++;
        if (ex_mc_done_o !== 1'b1 || stall_o !== 6'b0 || busy_o !== 1'b0) begin
            err++;
            $display("FAIL len0: done=%b stall=%b busy=%b want 1/000000/0",
                     ex_mc_done_o, stall_o, busy_o);
        end
        next_cycle();
        ex_mc_req_i = 1'b0;
        @(negedge clk);
        vec++;
        if (busy_o !== 1'b0 || stall_cnt_o !== 32'd0) begin
            err++;
            $display("FAIL len0_after: busy=%b cnt=%0d want 0/0",
                     busy_o, stall_cnt_o);
        end
        next_cycle();

        pulse_reset();
        ex_mc_req_i = 1'b1;
        ex_mc_len_i = 6'd1;
        @(negedge clk);
        vec++;
        if (stall_o !== 6'b001111 || ex_mc_done_o !== 1'b0) begin
            err++;
            $display("FAIL len1_c0: stall=%b done=%b want 001111/0",
                     stall_o, ex_mc_done_o);
        end
        next_cycle();
        set_ld_haz(1'b1);
        @(negedge clk);
        vec++;
        if (stall_o !== 6'b000111 || ex_mc_done_o !== 1'b1 || busy_o !== 1'b1) begin
            err++;
            $display("FAIL len1_done_lu: stall=%b done=%b busy=%b want 000111/1/1",
                     stall_o, ex_mc_done_o, busy_o);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vec++;
        if (stall_cnt_o !== 32'd2 || busy_o !== 1'b0) begin
            err++;
            $display("FAIL len1_cnt: cnt=%0d busy=%b want 2/0", stall_cnt_o, busy_o);
        end
        next_cycle();

        pulse_reset();
        ex_mc_req_i = 1'b1;
        ex_mc_len_i = 6'd63;
        stalls  = 0;
        done_at = -1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (stall_o == 6'b001111) stalls++;
            if (ex_mc_done_o === 1'b1 && done_at < 0) done_at = c;
            next_cycle();
        end
        ex_mc_req_i = 1'b0;
        @(negedge clk);
        vec++;
        if (stalls != 63 || done_at != 63) begin
            err++;
            $display("FAIL len63: stalls=%0d done_at=%0d want 63/63", stalls, done_at);
        end
        vec++;
        if (stall_cnt_o !== 32'd63 || busy_o !== 1'b0) begin
            err++;
            $display("FAIL len63_cnt: cnt=%0d busy=%b want 63/0", stall_cnt_o, busy_o);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_stall [6];
        logic       exp_done  [6];
        exp_stall = '{6'b001111, 6'b001111, 6'b0, 6'b001111, 6'b001111, 6'b0};
        exp_done  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        pulse_reset();
        ex_mc_req_i = 1'b1;
        ex_mc_len_i = 6'd2;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vec++;
            if (stall_o !== exp_stall[c] || ex_mc_done_o !== exp_done[c]) begin
                err++;
                $display("FAIL b2b c%0d: stall=%b done=%b want %b/%b",
                         c, stall_o, ex_mc_done_o, exp_stall[c], exp_done[c]);
            end
            next_cycle();
        end
        ex_mc_req_i = 1'b0;
        @(negedge clk);
        vec++;
        if (stall_cnt_o !== 32'd4) begin
            err++;
            $display("FAIL b2b_cnt: got %0d want 4", stall_cnt_o);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        logic seen_done;
        seen_done = 1'b0;
        pulse_reset();
        ex_mc_req_i = 1'b1;
        ex_mc_len_i = 6'd10;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ex_mc_done_o === 1'b1) seen_done = 1'b1;
            next_cycle();
        end
        flush_i = 1'b1;
        set_ld_haz(1'b1);
        @(negedge clk);
        vec++;
        if (stall_o !== 6'b0 || ex_mc_done_o !== 1'b0 || busy_o !== 1'b1) begin
            err++;
            $display("FAIL flush_c4: stall=%b done=%b busy=%b want 000000/0/1",
                     stall_o, ex_mc_done_o, busy_o);
        end
        next_cycle();
        clear_inputs();
        for (int c = 5; c < 8; c++) begin
            @(negedge clk);
            if (ex_mc_done_o === 1'b1) seen_done = 1'b1;
            vec++;
            if (busy_o !== 1'b0 || stall_o !== 6'b0) begin
                err++;
                $display("FAIL flush_idle c%0d: busy=%b stall=%b want 0/000000",
                         c, busy_o, stall_o);
            end
            next_cycle();
        end
        vec++;
        if (seen_done !== 1'b0 || stall_cnt_o !== 32'd4) begin
            err++;
            $display("FAIL flush_tail: done_seen=%b cnt=%0d want 0/4",
                     seen_done, stall_cnt_o);
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        ex_mc_req_i = 1'b1;
        ex_mc_len_i = 6'd20;
        for (int c = 0; c < 20; c++) next_cycle();
        ex_mc_req_i = 1'b0;
        next_cycle();
        @(negedge clk);
        vec++;
        if (s4_cnt_o !== 4'd15) begin
            err++;
            $display("FAIL sat4: got %0d want 15", s4_cnt_o);
        end
        vec++;
        if (stall_cnt_o !== 32'd20) begin
            err++;
            $display("FAIL sat32: got %0d want 20", stall_cnt_o);
        end
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_multicycle();
        test_edge_lengths();
        test_back_to_back();
        test_flush();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
